// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_W_DEFAULT   = 32'sd32;
  localparam int CLKDIV_DEFAULT_DIV = 32'sd250000;

  typedef logic [CLKDIV_W_DEFAULT-1:0] div_t;

  // Ceiling log2 with a floor of one bit, so a single channel still has an index port.
  function automatic int clkdiv_clog2(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 32'sd1;
      end
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor pair, pending flag,
// registered tick pulse and 50% square output.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int             W           = CLKDIV_W_DEFAULT,
  parameter logic [W-1:0]   DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         pending_o,
  output logic         tick_o,
  output logic         sq_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_active_q, div_active_d;
  logic [W-1:0] div_shadow_q, div_shadow_d;
  logic         pending_q, pending_d;
  logic         tick_q, tick_d;
  logic         sq_q, sq_d;
  logic         halted_s, run_s, tc_s, apply_s;

  assign halted_s = (div_active_q == '0);
  assign run_s    = en_i && !halted_s && !sync_clr_i;
  // >= so a divisor shrunk (while disabled) below the frozen count wraps at once.
  assign tc_s     = run_s && (cnt_q >= (div_active_q - {{(W-1){1'b0}}, 1'b1}));
  assign apply_s  = pending_q && (sync_clr_i || halted_s || !en_i || tc_s);

  // Next-state logic for counter, outputs and divisor handover.
  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    sq_d         = sq_q;
    div_shadow_d = div_shadow_q;
    pending_d    = pending_q;
    if (sync_clr_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (tc_s) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
    end else if (run_s) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else if (halted_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
    div_active_d = apply_s ? div_shadow_q : div_active_q;
    // A write landing with an apply keeps pending: the old shadow is what moved.
    if (load_i) begin
      div_shadow_d = load_val_i;
      pending_d    = 1'b1;
    end else if (apply_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      div_active_q <= DEFAULT_DIV;
      div_shadow_q <= DEFAULT_DIV;
      pending_q    <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      pending_q    <= pending_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
    end
  end

  assign pending_o = pending_q;
  assign tick_o    = tick_q;
  assign sq_o      = sq_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// CH independent programmable dividers sharing one divisor write port.
module multi_channel_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int           CH          = 32'sd4,
  parameter int           W           = CLKDIV_W_DEFAULT,
  parameter logic [W-1:0] DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV),
  localparam int          CHW         = clkdiv_clog2(CH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  en_i,
  input  logic [CH-1:0]  sync_clr_i,
  input  logic           wr_en_i,
  input  logic [CHW-1:0] wr_ch_i,
  input  logic [W-1:0]   wr_div_i,
  output logic           wr_ack_o,
  output logic           wr_err_o,
  output logic [CH-1:0]  pending_o,
  output logic [CH-1:0]  tick_o,
  output logic [CH-1:0]  sq_o
);

  // One extra bit so CH itself is representable when CH is a power of two.
  localparam logic [CHW:0] CH_LIM = CH[CHW:0];

  logic          wr_valid_s;
  logic [CH-1:0] load_s;
  logic          wr_ack_q, wr_err_q;

  assign wr_valid_s = wr_en_i && ({1'b0, wr_ch_i} < CH_LIM);

  // Decode the write target into per-channel load strobes.
  always_comb begin
    load_s = '0;
    for (int i = 0; i < CH; i++) begin
      load_s[i] = wr_valid_s && (wr_ch_i == i[CHW-1:0]);
    end
  end

  // Write handshake pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_valid_s;
      wr_err_q <= wr_en_i && !wr_valid_s;
    end
  end

  assign wr_ack_o = wr_ack_q;
  assign wr_err_o = wr_err_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    clk_div_channel #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i[g]),
      .sync_clr_i (sync_clr_i[g]),
      .load_i     (load_s[g]),
      .load_val_i (wr_div_i),
      .pending_o  (pending_o[g]),
      .tick_o     (tick_o[g]),
      .sq_o       (sq_o[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed + randomized bench for multi_channel_clock_divider against a
// period-counting reference model.
module tb_multi_channel_clock_divider;

  localparam int CH  = 5;
  localparam int W   = 16;
  localparam int DEF = 4;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  en, sync_clr;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_div;
  logic           wr_ack, wr_err;
  logic [CH-1:0]  pending, tick, sq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: divisor in force, queued divisor, enabled cycles into
  // the current period, and periods completed since the last clear.
  int m_div[CH], m_shadow[CH], m_elapsed[CH], m_periods[CH];
  bit m_pend[CH], m_tick[CH];
  bit m_ack, m_err;

  always #5 clk = ~clk;

  multi_channel_clock_divider #(
    .CH          (CH),
    .W           (W),
    .DEFAULT_DIV (16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .sync_clr_i (sync_clr),
    .wr_en_i    (wr_en),
    .wr_ch_i    (wr_ch),
    .wr_div_i   (wr_div),
    .wr_ack_o   (wr_ack),
    .wr_err_o   (wr_err),
    .pending_o  (pending),
    .tick_o     (tick),
    .sq_o       (sq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i] = DEF; m_shadow[i] = DEF; m_elapsed[i] = 0; m_periods[i] = 0;
      m_pend[i] = 1'b0; m_tick[i] = 1'b0;
    end
    m_ack = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit valid, counting, period_done, adopt;
    valid = wr_en && (int'(wr_ch) < CH);
    for (int i = 0; i < CH; i++) begin
      counting    = en[i] && (m_div[i] != 0) && !sync_clr[i];
      period_done = counting && (m_elapsed[i] + 1 >= m_div[i]);
      adopt       = m_pend[i] && (sync_clr[i] || m_div[i] == 0 || !en[i] || period_done);
      m_tick[i]   = period_done;
      if (sync_clr[i]) begin
        m_elapsed[i] = 0; m_periods[i] = 0;
      end else if (period_done) begin
        m_elapsed[i] = 0; m_periods[i] = m_periods[i] + 1;
      end else if (counting) begin
        m_elapsed[i] = m_elapsed[i] + 1;
      end else if (m_div[i] == 0) begin
        m_elapsed[i] = 0;
      end
      if (adopt) m_div[i] = m_shadow[i];
      if (valid && int'(wr_ch) == i) begin
        m_shadow[i] = int'(wr_div);
        m_pend[i]   = 1'b1;
      end else if (adopt) begin
        m_pend[i] = 1'b0;
      end
    end
    m_ack = valid;
    m_err = wr_en && !valid;
  endtask

  task automatic step();
    logic [CH-1:0] e_tick, e_sq, e_pend;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int i = 0; i < CH; i++) begin
      e_tick[i] = m_tick[i];
      e_sq[i]   = (m_periods[i] % 2) != 0;
      e_pend[i] = m_pend[i];
    end
    chk("tick", 32'(tick), 32'(e_tick));
    chk("sq", 32'(sq), 32'(e_sq));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("wr_err", 32'(wr_err), 32'(m_err));
  endtask

  task automatic write(input int ch, input int dv);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_div = W'(dv);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ack_err", {30'd0, wr_ack, wr_err}, 32'd0);
    model_reset();
    cyc = 0;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '1; sync_clr = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    #3;
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_sq", 32'(sq), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ack_err", {30'd0, wr_ack, wr_err}, 32'd0);
    model_reset();
    #4;
    rst = 1'b0;

    step(); step();                                   // cycles 1,2
    write(1, 6);
    step();                                           // cycle 3
    chk("ack_c3", 32'(wr_ack), 32'd1);
    chk("pend1_c3", 32'(pending), 32'h02);
    wr_en = 1'b0;
    step();                                           // cycle 4
    chk("tick_all_c4", 32'(tick), 32'h1f);
    chk("sq_all_c4", 32'(sq), 32'h1f);
    chk("pend_clear_c4", 32'(pending), 32'd0);
    write(2, 0);
    step();                                           // cycle 5
    wr_en = 1'b0;
    step();                                           // cycle 6, ch3 count = 2
    en[3] = 1'b0;
    step(); step();                                   // cycles 7,8
    chk("tick0_c8", 32'(tick[0]), 32'd1);
    chk("sq0_c8", 32'(sq[0]), 32'd0);
    chk("tick3_off_c8", 32'(tick[3]), 32'd0);
    write(5, 9);
    step();                                           // cycle 9
    chk("err_c9", 32'(wr_err), 32'd1);
    chk("noack_c9", 32'(wr_ack), 32'd0);
    chk("nopend_c9", 32'(pending), 32'd0);
    write(2, 3);
    step();                                           // cycle 10
    chk("tick1_c10", 32'(tick[1]), 32'd1);
    chk("tick2_halt_c10", 32'(tick[2]), 32'd0);
    wr_en = 1'b0;
    step(); step(); step();                           // cycles 11..13
    chk("tick2_c13", 32'(tick[2]), 32'd0);
    step();                                           // cycle 14
    chk("tick2_c14", 32'(tick[2]), 32'd1);
    step(); step();                                   // cycles 15,16
    chk("tick1_c16", 32'(tick[1]), 32'd1);
    en[3] = 1'b1;
    step();                                           // cycle 17
    chk("tick3_c17", 32'(tick[3]), 32'd0);
    step();                                           // cycle 18
    chk("tick3_c18", 32'(tick[3]), 32'd1);
    write(0, 2);
    step();                                           // cycle 19
    wr_en = 1'b0;
    sync_clr[0] = 1'b1;
    step();                                           // cycle 20
    chk("clr_sq0", 32'(sq[0]), 32'd0);
    chk("clr_pend0", 32'(pending[0]), 32'd0);
    sync_clr[0] = 1'b0;
    step(); step();                                   // cycles 21,22
    chk("tick0_c22", 32'(tick[0]), 32'd1);
    step();
    async_reset();
    step(); step(); step(); step();
    chk("tick_all_after_rst", 32'(tick), 32'h1f);

    for (int n = 0; n < 500; n++) begin
      en       = CH'($urandom) | CH'($urandom) | CH'($urandom);
      sync_clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_ch    = CHW'($urandom_range(0, 7));
      wr_div   = W'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) async_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
